// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock enable.
// Optional pix_req look-ahead output is built when VGA_PIX_REQ_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Pix_en,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          vga_on,
  output logic [XW-1:0] CounterX,
  output logic [YW-1:0] CounterY,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_PIX_REQ_EN
  ,output logic         pix_req
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          H_LVL    = 1'(H_POL);
  localparam logic          V_LVL    = 1'(V_POL);

  logic [XW-1:0] x_q, x_nxt;
  logic [YW-1:0] y_q, y_nxt;
  logic          hs_nxt, vs_nxt, on_nxt;

  always_comb begin
    x_nxt = x_q + XW'(1);
    y_nxt = y_q;
    if (x_q == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
    end
  end

  // Outputs are decoded from the position being entered so they register alongside it.
  always_comb begin
    hs_nxt = (x_nxt >= X_HS_BEG) && (x_nxt <= X_HS_END);
    vs_nxt = (y_nxt >= Y_VS_BEG) && (y_nxt <= Y_VS_END);
    on_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x_q         <= X_LAST;
      y_q         <= Y_LAST;
      vga_h_sync  <= ~H_LVL;
      vga_v_sync  <= ~V_LVL;
      vga_on      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (Pix_en) begin
        x_q         <= x_nxt;
        y_q         <= y_nxt;
        vga_h_sync  <= hs_nxt ? H_LVL : ~H_LVL;
        vga_v_sync  <= vs_nxt ? V_LVL : ~V_LVL;
        vga_on      <= on_nxt;
        line_start  <= (x_nxt == '0);
        frame_start <= (x_nxt == '0) && (y_nxt == '0);
      end
    end
  end

  assign CounterX = x_q;
  assign CounterY = y_q;

`ifdef VGA_PIX_REQ_EN
  // Looks one more pixel ahead so a synchronous ROM read lines up with vga_on.
  logic [XW-1:0] x_nn;
  logic [YW-1:0] y_nn;
  logic          req_nxt;

  always_comb begin
    x_nn = x_nxt + XW'(1);
    y_nn = y_nxt;
    if (x_nxt == X_LAST) begin
      x_nn = '0;
      y_nn = (y_nxt == Y_LAST) ? '0 : y_nxt + YW'(1);
    end
    req_nxt = (x_nn < X_ACT) && (y_nn < Y_ACT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pix_req <= 1'b0;
    end else if (Pix_en) begin
      pix_req <= req_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny active-high instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic        hs0, vs0, on0, ls0, fs0, pr0;
  logic [9:0]  cx0, cy0;
  logic        hs1, vs1, on1, ls1, fs1, pr1;
  logic [3:0]  cx1, cy1;

  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_gen dut0 (
    .Clk(clk), .Rst_n(rst_n), .Pix_en(pix_en),
    .vga_h_sync(hs0), .vga_v_sync(vs0), .vga_on(on0),
    .CounterX(cx0), .CounterY(cy0),
    .line_start(ls0), .frame_start(fs0)
`ifdef VGA_PIX_REQ_EN
    ,.pix_req(pr0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .XW(4), .YW(4)
  ) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Pix_en(pix_en),
    .vga_h_sync(hs1), .vga_v_sync(vs1), .vga_on(on1),
    .CounterX(cx1), .CounterY(cy1),
    .line_start(ls1), .frame_start(fs1)
`ifdef VGA_PIX_REQ_EN
    ,.pix_req(pr1)
`endif
  );

`ifndef VGA_PIX_REQ_EN
  assign pr0 = 1'b0;
  assign pr1 = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic hs, vs, on, ls, fs, pr;
  } exp_t;

  // Position kept as a linear pixel index into the frame.
  function automatic exp_t model(input int idx, input bit adv, input bit started,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht, n, nx;
    ht  = ha + hf + hsw + hb;
    n   = ht * (va + vf + vsw + vb);
    e.x = idx % ht;
    e.y = idx / ht;
    e.hs = (int'(e.x) >= ha + hf && int'(e.x) < ha + hf + hsw) ? hp : !hp;
    e.vs = (int'(e.y) >= va + vf && int'(e.y) < va + vf + vsw) ? vp : !vp;
    e.on = (int'(e.x) < ha) && (int'(e.y) < va);
    e.ls = adv && (e.x == 0);
    e.fs = adv && (idx == 0);
    nx   = (idx + 1) % n;
    e.pr = started && ((nx % ht) < ha) && ((nx / ht) < va);
    return e;
  endfunction

  localparam int N0 = 800 * 525;
  localparam int N1 = 15 * 9;

  int m0_idx = N0 - 1, m1_idx = N1 - 1;
  bit m_adv = 1'b0, m_started = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_idx    <= N0 - 1;
      m1_idx    <= N1 - 1;
      m_adv     <= 1'b0;
      m_started <= 1'b0;
    end else if (pix_en) begin
      m0_idx    <= (m0_idx + 1) % N0;
      m1_idx    <= (m1_idx + 1) % N1;
      m_adv     <= 1'b1;
      m_started <= 1'b1;
    end else begin
      m_adv <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e0, e1;
    e0 = model(m0_idx, m_adv, m_started, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    e1 = model(m1_idx, m_adv, m_started, 8, 2, 3, 2, 5, 1, 2, 1, 1'b1, 1'b1);
    chk("d0_x", int'(cx0), int'(e0.x));
    chk("d0_y", int'(cy0), int'(e0.y));
    chk("d0_hs", int'(hs0), int'(e0.hs));
    chk("d0_vs", int'(vs0), int'(e0.vs));
    chk("d0_on", int'(on0), int'(e0.on));
    chk("d0_ls", int'(ls0), int'(e0.ls));
    chk("d0_fs", int'(fs0), int'(e0.fs));
    chk("d1_x", int'(cx1), int'(e1.x));
    chk("d1_y", int'(cy1), int'(e1.y));
    chk("d1_hs", int'(hs1), int'(e1.hs));
    chk("d1_vs", int'(vs1), int'(e1.vs));
    chk("d1_on", int'(on1), int'(e1.on));
    chk("d1_ls", int'(ls1), int'(e1.ls));
    chk("d1_fs", int'(fs1), int'(e1.fs));
`ifdef VGA_PIX_REQ_EN
    chk("d0_pr", int'(pr0), int'(e0.pr));
    chk("d1_pr", int'(pr1), int'(e1.pr));
`endif
  end

  initial begin
    int last0, last1, nls0, hs_low, vcnt;

    repeat (3) @(negedge clk);
    chk("rst_d0_x", int'(cx0), 799);
    chk("rst_d0_y", int'(cy0), 524);
    chk("rst_d0_hs", int'(hs0), 1);
    chk("rst_d0_vs", int'(vs0), 1);
    chk("rst_d0_on", int'(on0), 0);
    chk("rst_d0_fs", int'(fs0), 0);
    chk("rst_d1_x", int'(cx1), 14);
    chk("rst_d1_y", int'(cy1), 8);
    chk("rst_d1_hs", int'(hs1), 0);
    chk("rst_d1_vs", int'(vs1), 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("hold_d0_x", int'(cx0), 799);
    pix_en = 1'b1;
    @(negedge clk);
    chk("first_d0_x", int'(cx0), 0);
    chk("first_d0_y", int'(cy0), 0);
    chk("first_d0_fs", int'(fs0), 1);
    chk("first_d0_ls", int'(ls0), 1);
    chk("first_d0_on", int'(on0), 1);
    chk("first_d1_fs", int'(fs1), 1);
    @(negedge clk);
    chk("second_d0_fs", int'(fs0), 0);
    chk("second_d0_x", int'(cx0), 1);

    // Continuous enable: two full lines of dut0, many frames of dut1.
    last0 = -1; last1 = -1; nls0 = 0; hs_low = 0; vcnt = 0;
    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
      if (ls0) begin
        if (last0 >= 0) chk("d0_line_period", c - last0, 800);
        last0 = c;
        nls0++;
      end
      if (!hs0) hs_low++;
      if (fs1) begin
        if (last1 >= 0) begin
          chk("d1_frame_period", c - last1, 135);
          chk("d1_vsync_clks", vcnt, 30);
        end
        last1 = c;
        vcnt  = 0;
      end
      if (vs1) vcnt++;
    end
    chk("d0_hsync_low_clks", hs_low, 192);
    chk("d0_line_starts", nls0, 2);

    // Half-rate enable: periods double in Clk cycles.
    last0 = -1; last1 = -1;
    for (int c = 0; c < 3400; c++) begin
      @(negedge clk);
      if (ls0) begin
        if (last0 >= 0) chk("d0_line_period_half", c - last0, 1600);
        last0 = c;
      end
      if (fs1) begin
        if (last1 >= 0) chk("d1_frame_period_half", c - last1, 270);
        last1 = c;
      end
      pix_en = ~pix_en;
    end

    // Asynchronous reset between clock edges.
    pix_en = 1'b1;
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d0_x", int'(cx0), 799);
    chk("arst_d0_y", int'(cy0), 524);
    chk("arst_d0_hs", int'(hs0), 1);
    chk("arst_d0_on", int'(on0), 0);
    chk("arst_d1_x", int'(cx1), 14);
    chk("arst_d1_y", int'(cy1), 8);
    pix_en = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    pix_en = 1'b1;
    @(negedge clk);
    chk("restart_d0_x", int'(cx0), 0);
    chk("restart_d0_y", int'(cy0), 0);
    chk("restart_d0_fs", int'(fs0), 1);

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      pix_en = 1'($urandom_range(0, 1));
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
